// File: rtl/led_debug_ctrl_pkg.sv
// Shared encodings for the LED debug front end: view modes, byte-select type
// and the byte extraction helper used by the LED mux.
package led_debug_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_PC   = 2'd0,
        MODE_REG1 = 2'd1,
        MODE_REG2 = 2'd2
    } mode_t;

    typedef logic [1:0] byte_sel_t;

    function automatic logic [7:0] select_byte(input logic [31:0] value, input byte_sel_t sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = value[7:0];
            2'd1:    b = value[15:8];
            2'd2:    b = value[23:16];
            2'd3:    b = value[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchronizer, stability counter and a single-cycle
// pulse on each accepted 0->1 transition.
module btn_debounce
    import led_debug_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize, then accept the new level on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_r   <= {CNT_W{1'b0}};
                level_r <= sync2_r;
                press_r <= sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/led_debug_ctrl.sv
// Debug front end: three debounced buttons pick a view (PC / reg1 / reg2),
// and the LEDs rotate through the bytes of the selected 32-bit value.
module led_debug_ctrl
    import led_debug_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ROT_CYCLES      = 8
) (
    input  logic        mainClk,
    input  logic        reset,
    input  logic        chreg1,
    input  logic        chreg2,
    input  logic        chPC,
    input  logic [31:0] reg_data,
    input  logic [31:0] pc,
    output logic [4:0]  reg_addr,
    output logic [1:0]  mode,
    output logic [1:0]  byte_sel,
    output logic [7:0]  led
);

    localparam int ROT_W = (ROT_CYCLES > 1) ? $clog2(ROT_CYCLES) : 1;

    logic             pc_press_s;
    logic             reg1_press_s;
    logic             reg2_press_s;
    logic             any_press_s;
    mode_t            mode_r;
    logic [4:0]       idx1_r;
    logic [4:0]       idx2_r;
    logic [4:0]       reg_addr_r;
    logic [ROT_W-1:0] rot_cnt_r;
    byte_sel_t        byte_sel_r;
    logic [31:0]      disp_s;
    logic [7:0]       led_r;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pc (
        .clk(mainClk), .reset(reset), .raw(chPC), .press(pc_press_s)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reg1 (
        .clk(mainClk), .reset(reset), .raw(chreg1), .press(reg1_press_s)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reg2 (
        .clk(mainClk), .reset(reset), .raw(chreg2), .press(reg2_press_s)
    );

    assign any_press_s = pc_press_s | reg1_press_s | reg2_press_s;

    // View FSM: chPC beats chreg1 beats chreg2; repeat press in a register view steps its index.
    always_ff @(posedge mainClk) begin
        if (reset) begin
            mode_r     <= MODE_PC;
            idx1_r     <= 5'd0;
            idx2_r     <= 5'd0;
            reg_addr_r <= 5'd0;
        end else if (pc_press_s) begin
            mode_r     <= MODE_PC;
            reg_addr_r <= 5'd0;
        end else if (reg1_press_s) begin
            if (mode_r == MODE_REG1) begin
                idx1_r     <= idx1_r + 5'd1;
                reg_addr_r <= idx1_r + 5'd1;
            end else begin
                mode_r     <= MODE_REG1;
                reg_addr_r <= idx1_r;
            end
        end else if (reg2_press_s) begin
            if (mode_r == MODE_REG2) begin
                idx2_r     <= idx2_r + 5'd1;
                reg_addr_r <= idx2_r + 5'd1;
            end else begin
                mode_r     <= MODE_REG2;
                reg_addr_r <= idx2_r;
            end
        end
    end

    // Byte rotation; any accepted press (even a dropped one) restarts at byte 0.
    always_ff @(posedge mainClk) begin
        if (reset) begin
            rot_cnt_r  <= {ROT_W{1'b0}};
            byte_sel_r <= 2'd0;
        end else if (any_press_s) begin
            rot_cnt_r  <= {ROT_W{1'b0}};
            byte_sel_r <= 2'd0;
        end else if (rot_cnt_r == ROT_W'(ROT_CYCLES - 1)) begin
            rot_cnt_r  <= {ROT_W{1'b0}};
            byte_sel_r <= byte_sel_r + 2'd1;
        end else begin
            rot_cnt_r <= rot_cnt_r + ROT_W'(1);
        end
    end

    // Display source: live PC in PC view, register-file read data otherwise.
    always_comb begin
        if (mode_r == MODE_PC) begin
            disp_s = pc;
        end else begin
            disp_s = reg_data;
        end
    end

    // LED byte register, refreshed every cycle.
    always_ff @(posedge mainClk) begin
        if (reset) begin
            led_r <= 8'h00;
        end else begin
            led_r <= select_byte(disp_s, byte_sel_r);
        end
    end

    assign reg_addr = reg_addr_r;
    assign mode     = mode_r;
    assign byte_sel = byte_sel_r;
    assign led      = led_r;

endmodule

// File: tb/tb_led_debug_ctrl.sv
// Self-checking bench for led_debug_ctrl: expectations are queued with the
// cycle they are due, and a monitor compares them against the outputs.
module tb_led_debug_ctrl;

    localparam int DEB = 16;
    localparam int ROT = 8;

    localparam logic [3:0] M_LED  = 4'b0001;
    localparam logic [3:0] M_MODE = 4'b0010;
    localparam logic [3:0] M_BS   = 4'b0100;
    localparam logic [3:0] M_RA   = 4'b1000;

    logic        mainClk = 1'b0;
    logic        reset;
    logic        chreg1;
    logic        chreg2;
    logic        chPC;
    logic [31:0] reg_data;
    logic [31:0] pc;
    logic [4:0]  reg_addr;
    logic [1:0]  mode;
    logic [1:0]  byte_sel;
    logic [7:0]  led;

    typedef struct packed {
        int         at_cyc;
        logic [3:0] mask;
        logic [7:0] led;
        logic [1:0] mode;
        logic [1:0] bs;
        logic [4:0] ra;
    } exp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  led;
        logic [1:0]  bs;
    } rot_vec_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  cur;
    string cur_name;
    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;

    led_debug_ctrl #(.DEBOUNCE_CYCLES(DEB), .ROT_CYCLES(ROT)) dut (
        .mainClk (mainClk),
        .reset   (reset),
        .chreg1  (chreg1),
        .chreg2  (chreg2),
        .chPC    (chPC),
        .reg_data(reg_data),
        .pc      (pc),
        .reg_addr(reg_addr),
        .mode    (mode),
        .byte_sel(byte_sel),
        .led     (led)
    );

    // Register-file model: byte 0 encodes the read address, upper bytes are fixed markers.
    assign reg_data = {8'hD3, 8'hC2, 8'hB1, 3'b101, reg_addr};

    always #5 mainClk = ~mainClk;

    always @(posedge mainClk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge mainClk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick(1);
    endtask

    task automatic push(input int at, input string nm, input logic [3:0] m, input logic [7:0] l,
                        input logic [1:0] md, input logic [1:0] b, input logic [4:0] r);
        exp_t e;
        e.at_cyc = at;
        e.mask   = m;
        e.led    = l;
        e.mode   = md;
        e.bs     = b;
        e.ra     = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic cmp(input string nm, input string fld, input int c,
                       input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s.%s at cycle %0d: got %0h want %0h", nm, fld, c, got, want);
        end
    endtask

    // Scoreboard monitor: pops every expectation due this cycle.
    always begin
        @(posedge mainClk);
        #1;
        while (exp_q.size() > 0 && exp_q[0].at_cyc <= cyc) begin
            cur      = exp_q.pop_front();
            cur_name = name_q.pop_front();
            if (cur.at_cyc < cyc) begin
                cmp(cur_name, "due_cycle", cyc, 32'(cyc), 32'(cur.at_cyc));
            end else begin
                if (cur.mask[0]) cmp(cur_name, "led", cyc, 32'(led), 32'(cur.led));
                if (cur.mask[1]) cmp(cur_name, "mode", cyc, 32'(mode), 32'(cur.mode));
                if (cur.mask[2]) cmp(cur_name, "byte_sel", cyc, 32'(byte_sel), 32'(cur.bs));
                if (cur.mask[3]) cmp(cur_name, "reg_addr", cyc, 32'(reg_addr), 32'(cur.ra));
            end
        end
    end

    // Raw press held 25 cycles then released 25 cycles; outcome expected DEB+3 edges after the rise.
    task automatic press(input logic p, input logic r1, input logic r2, input string nm,
                         input logic [1:0] old_md, input logic [4:0] old_ra,
                         input logic [1:0] new_md, input logic [4:0] new_ra, input bit rot_chk);
        int         t;
        logic [7:0] l0;
        t  = cyc;
        l0 = (new_md == 2'd0) ? pc[7:0] : {3'b101, new_ra};
        push(t + DEB + 2, {nm, "_before"}, M_MODE | M_RA, 8'h00, old_md, 2'd0, old_ra);
        push(t + DEB + 3, nm, M_MODE | M_RA | M_BS, 8'h00, new_md, 2'd0, new_ra);
        push(t + DEB + 4, {nm, "_led"}, M_LED, l0, 2'd0, 2'd0, 5'd0);
        if (rot_chk) begin
            push(t + DEB + 3 + ROT, {nm, "_dwell"}, M_LED, l0, 2'd0, 2'd0, 5'd0);
            push(t + DEB + 4 + ROT, {nm, "_rot"}, M_LED, 8'hB1, 2'd0, 2'd0, 5'd0);
        end
        chPC   = p;
        chreg1 = r1;
        chreg2 = r2;
        tick(25);
        chPC   = 1'b0;
        chreg1 = 1'b0;
        chreg2 = 1'b0;
        tick(25);
    endtask

    initial begin
        rot_vec_t rot_tab[9];
        int       t;

        rot_tab[0] = '{32'h1234_5678, 8'h78, 2'd0};
        rot_tab[1] = '{32'h1234_5678, 8'h56, 2'd1};
        rot_tab[2] = '{32'h1234_5678, 8'h34, 2'd2};
        rot_tab[3] = '{32'h1234_5678, 8'h12, 2'd3};
        rot_tab[4] = '{32'h1234_5678, 8'h78, 2'd0};
        rot_tab[5] = '{32'hA5C3_0FF0, 8'h0F, 2'd1};
        rot_tab[6] = '{32'hA5C3_0FF0, 8'hC3, 2'd2};
        rot_tab[7] = '{32'hA5C3_0FF0, 8'hA5, 2'd3};
        rot_tab[8] = '{32'hDEAD_BEEF, 8'hEF, 2'd0};

        reset  = 1'b1;
        chreg1 = 1'b0;
        chreg2 = 1'b0;
        chPC   = 1'b0;
        pc     = 32'h0000_0040;
        push(3, "reset_state", M_LED | M_MODE | M_BS | M_RA, 8'h00, 2'd0, 2'd0, 5'd0);
        tick(5);
        reset = 1'b0;
        push(6, "reset_release", M_LED | M_MODE | M_BS, 8'h40, 2'd0, 2'd0, 5'd0);
        tick(1);

        // Rotation: each table row covers one 8-cycle byte window on the LEDs.
        for (int k = 0; k < 9; k++) begin
            int first;
            int last;
            first = (k == 0) ? 7 : 6 + 8 * k;
            last  = 13 + 8 * k;
            wait_until(first - 1);
            pc = rot_tab[k].pc;
            for (int c = first; c <= last; c++) begin
                if (c == first) push(c, "rot_start", M_LED | M_BS, rot_tab[k].led, 2'd0, rot_tab[k].bs, 5'd0);
                else            push(c, "rot_hold", M_LED, rot_tab[k].led, 2'd0, 2'd0, 5'd0);
            end
        end
        wait_until(78);

        // Glitch of 10 synchronized cycles must be ignored.
        t = cyc;
        push(t + 20, "glitch", M_MODE | M_RA, 8'h00, 2'd0, 2'd0, 5'd0);
        push(t + 30, "glitch_late", M_MODE | M_RA, 8'h00, 2'd0, 2'd0, 5'd0);
        chreg1 = 1'b1;
        tick(10);
        chreg1 = 1'b0;
        tick(40);

        press(1'b0, 1'b1, 1'b0, "reg1_enter", 2'd0, 5'd0, 2'd1, 5'd0, 1'b1);
        press(1'b0, 1'b1, 1'b0, "reg1_inc",   2'd1, 5'd0, 2'd1, 5'd1, 1'b0);
        press(1'b0, 1'b0, 1'b1, "reg2_enter", 2'd1, 5'd1, 2'd2, 5'd0, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            press(1'b0, 1'b0, 1'b1, "reg2_step", 2'd2, 5'(i - 1), 2'd2, 5'(i), 1'b0);
        end
        press(1'b0, 1'b1, 1'b0, "reg1_kept",  2'd2, 5'd0, 2'd1, 5'd1, 1'b0);
        press(1'b0, 1'b0, 1'b1, "reg2_back",  2'd1, 5'd1, 2'd2, 5'd0, 1'b0);
        press(1'b1, 1'b1, 1'b0, "pc_wins",    2'd2, 5'd0, 2'd0, 5'd0, 1'b0);
        press(1'b0, 1'b1, 1'b0, "idx1_same",  2'd0, 5'd0, 2'd1, 5'd1, 1'b0);
        press(1'b1, 1'b0, 1'b0, "pc_select",  2'd1, 5'd1, 2'd0, 5'd0, 1'b0);
        press(1'b0, 1'b1, 1'b1, "r1_over_r2", 2'd0, 5'd0, 2'd1, 5'd1, 1'b0);
        press(1'b0, 1'b1, 1'b1, "r1_inc_dup", 2'd1, 5'd1, 2'd1, 5'd2, 1'b0);
        press(1'b0, 1'b0, 1'b1, "r2_dropped", 2'd1, 5'd2, 2'd2, 5'd0, 1'b0);

        // Reset at debounce count 10 with chreg1 held: full latency restarts after release.
        t = cyc;
        push(t + 13, "mid_reset", M_LED | M_MODE | M_BS | M_RA, 8'h00, 2'd0, 2'd0, 5'd0);
        push(t + 14 + DEB + 2, "post_reset_wait", M_MODE | M_RA, 8'h00, 2'd0, 2'd0, 5'd0);
        push(t + 14 + DEB + 3, "post_reset_press", M_MODE | M_RA | M_BS, 8'h00, 2'd1, 2'd0, 5'd0);
        push(t + 14 + DEB + 4, "post_reset_led", M_LED, 8'hA0, 2'd0, 2'd0, 5'd0);
        chreg1 = 1'b1;
        tick(12);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(30);
        chreg1 = 1'b0;
        tick(30);

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick(1);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
